// File: rtl/addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: controller states
// and the mode encoding used by the datapath cell.
package addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_fas_cell.sv
// One-bit full adder/subtractor built only from 2-input NAND terms.
// Subtraction reuses the carry network with x inverted (x ^ mode).
module fas_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  input  logic mode,
  output logic out,
  output logic cout_bout
);

  logic xy_n, xy, xyc_n;
  logic xmd_n, xm, xmy_n, xmy;

  // Each XOR is the classic four-NAND structure.
  assign xy_n  = ~(x & y);
  assign xy    = ~(~(x & xy_n) & ~(y & xy_n));
  assign xyc_n = ~(xy & cin);
  assign out   = ~(~(xy & xyc_n) & ~(cin & xyc_n));

  assign xmd_n = ~(x & mode);
  assign xm    = ~(~(x & xmd_n) & ~(mode & xmd_n));
  assign xmy_n = ~(xm & y);
  assign xmy   = ~(~(xm & xmy_n) & ~(y & xmy_n));

  assign cout_bout = ~(~(xm & y) & ~(cin & xmy));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one bit per clock, LSB first, through a single
// fas_cell, with a start/busy/done handshake.
//
// state   | meaning
// IDLE    | waiting for start
// RUN     | shifting operands through the cell, one bit per edge
// DONE    | one-cycle done pulse; start here issues back-to-back
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr, acc;
  logic             mode_r;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             bit_s, carry_next, last, ovf_next;
  logic [WIDTH-1:0] acc_next;

  fas_cell u_cell (
    .x        (a_sr[0]),
    .y        (b_sr[0]),
    .cin      (carry),
    .mode     (mode_r),
    .out      (bit_s),
    .cout_bout(carry_next)
  );

  assign last     = (cnt == CW'(WIDTH - 1));
  assign acc_next = {bit_s, acc[WIDTH-1:1]};

  // On the last bit the cell inputs are the operand MSBs.
  assign ovf_next = (mode_r == MODE_ADD)
                  ? ((a_sr[0] == b_sr[0]) && (bit_s != a_sr[0]))
                  : ((a_sr[0] != b_sr[0]) && (bit_s != a_sr[0]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      acc    <= '0;
      mode_r <= MODE_ADD;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            mode_r <= mode;
            carry  <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            busy   <= 1'b1;
            state  <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= carry_next;
          acc   <= acc_next;
          cnt   <= cnt + CW'(1);
          if (last) begin
            result <= acc_next;
            cout   <= carry_next;
            ovf    <= ovf_next;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench: WIDTH=8 directed/random operations and an exhaustive
// WIDTH=2 sweep, checked against an arithmetic reference model.
module tb_serial_addsub;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, mode;
  logic [7:0] a, b;
  logic       busy, done, cout, ovf;
  logic [7:0] result;

  logic       start2, mode2;
  logic [1:0] a2, b2;
  logic       busy2, done2, cout2, ovf2;
  logic [1:0] result2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
  );

  serial_addsub #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .mode(mode2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .result(result2), .cout(cout2), .ovf(ovf2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  task automatic model(input int w, input longint av, input longint bv, input logic m,
                       output longint res, output logic co, output logic ov);
    longint md, full, sa, sb, sr;
    md = longint'(1) << w;
    sa = (av >= md / 2) ? av - md : av;
    sb = (bv >= md / 2) ? bv - md : bv;
    if (m == 1'b0) begin
      full = av + bv;
      co   = (full >= md);
      sr   = sa + sb;
    end else begin
      full = av - bv;
      co   = (av < bv);
      sr   = sa - sb;
    end
    res = ((full % md) + md) % md;
    ov  = (sr >= md / 2) || (sr < -(md / 2));
  endtask

  // Issues one WIDTH=8 operation from the current negedge and waits for done.
  task automatic run8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input logic m, input bit inject);
    longint     er;
    logic       ec, eo;
    logic [7:0] prev_res;
    logic       prev_c, prev_o;
    int         lat;
    bit         busy_ok, hold_ok;
    model(8, longint'(av), longint'(bv), m, er, ec, eo);
    prev_res = result;
    prev_c   = cout;
    prev_o   = ovf;
    start = 1'b1; a = av; b = bv; mode = m;
    @(negedge clk);
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); mode = 1'($urandom);
    busy_ok = (busy === 1'b1);
    hold_ok = 1'b1;
    lat     = 0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = j;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (result !== prev_res || cout !== prev_c || ovf !== prev_o) hold_ok = 1'b0;
      if (inject && (j == 2 || j == 5)) begin
        start = 1'b1; a = 8'($urandom); b = 8'($urandom); mode = ~m;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, " latency"}, 64'(lat), 64'd8);
    check({tag, " busy_during_run"}, {63'b0, busy_ok}, 64'd1);
    check({tag, " outputs_held"}, {63'b0, hold_ok}, 64'd1);
    check({tag, " busy_at_done"}, {63'b0, busy}, 64'd0);
    check({tag, " result"}, {56'b0, result}, 64'(er));
    check({tag, " cout"}, {63'b0, cout}, {63'b0, ec});
    check({tag, " ovf"}, {63'b0, ovf}, {63'b0, eo});
  endtask

  task automatic quiet8(input string tag);
    @(negedge clk);
    check({tag, " done_single"}, {63'b0, done}, 64'd0);
    check({tag, " idle_busy"}, {63'b0, busy}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint er;
    logic   ec, eo;
    int     lat, pulses;

    rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0;
    start2 = 1'b0; mode2 = 1'b0; a2 = '0; b2 = '0;
    #2;
    check("reset busy", {63'b0, busy}, 64'd0);
    check("reset done", {63'b0, done}, 64'd0);
    check("reset result", {56'b0, result}, 64'd0);
    check("reset cout", {63'b0, cout}, 64'd0);
    check("reset ovf", {63'b0, ovf}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run8("add_100_27", 8'd100, 8'd27, 1'b0, 1'b0);
    check("add_100_27 literal", {56'b0, result}, 64'd127);
    quiet8("add_100_27");
    run8("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0);
    check("add_7f_01 ovf literal", {63'b0, ovf}, 64'd1);
    quiet8("add_7f_01");
    run8("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
    check("add_ff_01 cout literal", {63'b0, cout}, 64'd1);
    quiet8("add_ff_01");
    run8("sub_5_7", 8'd5, 8'd7, 1'b1, 1'b0);
    check("sub_5_7 literal", {56'b0, result}, 64'hFE);
    quiet8("sub_5_7");
    run8("sub_80_1", 8'h80, 8'h01, 1'b1, 1'b0);
    check("sub_80_1 literal", {56'b0, result}, 64'h7F);
    quiet8("sub_80_1");

    run8("ignored_start", 8'h35, 8'h4A, 1'b0, 1'b1);
    quiet8("ignored_start");

    // Back-to-back: second issue lands in the DONE cycle of the first.
    run8("b2b_first", 8'hC3, 8'h5A, 1'b1, 1'b0);
    run8("b2b_second", 8'h12, 8'hF0, 1'b0, 1'b0);
    quiet8("b2b_second");

    // Reset mid-operation.
    start = 1'b1; a = 8'h66; b = 8'h11; mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst busy", {63'b0, busy}, 64'd0);
    check("midrst done", {63'b0, done}, 64'd0);
    check("midrst result", {56'b0, result}, 64'd0);
    check("midrst cout", {63'b0, cout}, 64'd0);
    check("midrst ovf", {63'b0, ovf}, 64'd0);
    pulses = 0;
    repeat (3) begin
      @(posedge clk);
      #1 if (done === 1'b1) pulses++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("midrst no_done", 64'(pulses), 64'd0);
    run8("after_reset", 8'h66, 8'h11, 1'b0, 1'b0);
    quiet8("after_reset");

    for (int i = 0; i < 20; i++) begin
      run8($sformatf("rand%0d", i), 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    end
    quiet8("rand_end");

    for (int m = 0; m < 2; m++) begin
      for (int av = 0; av < 4; av++) begin
        for (int bv = 0; bv < 4; bv++) begin
          model(2, longint'(av), longint'(bv), 1'(m), er, ec, eo);
          start2 = 1'b1; a2 = 2'(av); b2 = 2'(bv); mode2 = 1'(m);
          @(negedge clk);
          start2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom);
          lat = 0; pulses = 0;
          for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            if (done2 === 1'b1) begin
              pulses++;
              if (lat == 0) begin
                lat = j;
                check($sformatf("w2 m%0d %0d,%0d result", m, av, bv), {62'b0, result2}, 64'(er));
                check($sformatf("w2 m%0d %0d,%0d cout", m, av, bv), {63'b0, cout2}, {63'b0, ec});
                check($sformatf("w2 m%0d %0d,%0d ovf", m, av, bv), {63'b0, ovf2}, {63'b0, eo});
              end
            end
          end
          check($sformatf("w2 m%0d %0d,%0d latency", m, av, bv), 64'(lat), 64'd2);
          check($sformatf("w2 m%0d %0d,%0d pulses", m, av, bv), 64'(pulses), 64'd1);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Parametrised bit-serial adder/subtractor. Processes one bit per clock, LSB first, through a single 1-bit full adder/subtractor cell. Generalises the half-subtractor datapath to WIDTH bits, a selectable add/sub mode, carry/borrow chaining and signed overflow. Uses a start/busy/done handshake and sits beside the combinational adder/subtractor library as the area-minimal arithmetic option.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; accepted only when busy=0.
mode  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start.
a  input  WIDTH  operand A; sampled with start.
b  input  WIDTH  operand B; sampled with start.
busy  output  1  high while an operation is in progress.
done  output  1  single-cycle pulse; result valid.
result  output  WIDTH  sum or difference.
cout  output  1  add: carry out of MSB; sub: borrow out of MSB (1 when a<b unsigned).
ovf  output  1  signed two's-complement overflow.

Behaviour:
- Clocking: one clock (clk). Reset is asynchronous and active-high (rst).
- States: IDLE, RUN, DONE.
- Reset values: state=IDLE; busy, done, result, cout and ovf all 0; internal operand shift registers, carry/borrow flop and bit counter all 0.
- Accept: start=1 at a rising edge while in IDLE or DONE latches a, b and mode. It also clears carry/borrow to 0 and the counter to 0, then moves to RUN.
- RUN behaviour:
  - At each edge, bit i (i=counter) is processed by the cell.
  - Add: s = a_i^b_i^c; c' = a_i&b_i | c&(a_i^b_i).
  - Sub: d = a_i^b_i^bw; bw' = ~a_i&b_i | bw&~(a_i^b_i).
  - The result bit shifts into the MSB of the accumulating shift register, and the counter increments.
- Completion: after the WIDTH-th RUN edge, the state moves to DONE.
  - result, cout and ovf load from the accumulator in the same edge.
  - done=1 for exactly that one cycle.
- Latency: the accepting edge is k, and done is high in the cycle after edge k+WIDTH. busy=1 from edge k through edge k+WIDTH-1, then drops together with done rising.
- From DONE: returns to IDLE on the next edge, or goes to RUN if start=1 on that edge (back-to-back issue; no bubble beyond the DONE cycle).
- start is ignored while busy=1. An ignored start has no effect on state, operands or outputs.
- result, cout and ovf hold their values until the next completion. They do not change during RUN.
- ovf rules:
  - Add: a[MSB]==b[MSB] and result[MSB]!=a[MSB].
  - Sub: a[MSB]!=b[MSB] and result[MSB]!=a[MSB].
- Width: arithmetic is modulo 2^WIDTH. cout carries the extra bit.
- Reset mid-operation: aborts immediately, with no done pulse. All outputs return to 0.
- Counter width: $clog2(WIDTH)+1 bits. It must not wrap before reaching WIDTH.

Decomposition:
- Shared package (addsub_pkg):
  - State encodings ST_IDLE, ST_RUN, ST_DONE.
  - Mode constants MODE_ADD=1'b0, MODE_SUB=1'b1.
- Sub-module: fas_cell, a combinational 1-bit full adder/subtractor built from NAND gates.
  - Ports: x, y, cin, mode, out, cout_bout.
  - Instanced once. All sequencing stays in serial_addsub.

Test Plan:
- Add, WIDTH=8: mode=0, a=100, b=27 -> done exactly 8 cycles after acceptance; result=127, cout=0, ovf=0.
- Signed add overflow: a=8'h7F, b=8'h01, mode=0 -> result=8'h80, cout=0, ovf=1. Also a=8'hFF, b=8'h01 -> result=8'h00, cout=1, ovf=0.
- Subtract with borrow: a=5, b=7, mode=1 -> result=8'hFE, cout=1, ovf=0. Also a=8'h80, b=1 -> result=8'h7F, cout=0, ovf=1.
- Handshake:
  - Pulse start again at cycles 2 and 5 of a RUN with different operands -> ignored; the first operation's result is unchanged.
  - start in the DONE cycle -> new operation begins; done again WIDTH+1 cycles after the previous done.
- Reset mid-operation: assert rst at RUN cycle 3 -> busy, done, result, cout and ovf are 0 asynchronously; no done pulse. The next start completes correctly.
- Exhaustive WIDTH=2 instance: all 16 (a,b) pairs × both modes -> result, cout and ovf match the reference model. done is pulsed exactly once per operation.
